pe0_addr_gen: RTL and testbench

//  Upstream sequencer for the radix-2 butterfly PE: walks all stages/butterflies of an N-point NTT/INTT.

---
 rtl/pe0_addr_gen.sv | 212 +++++++++++++++++++++
 tb/tb_pe0_addr_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pe0_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pe0_addr_gen                                                 |
// | Description : Butterfly sequencer for a radix-2 NTT/INTT processing        |
// |               element. Walks LOG_N stages of N/2 butterflies, issuing the  |
// |               u/v coefficient read addresses, the twiddle ROM address and  |
// |               the PE mode select. A delay line of depth RD_LAT+PE_LAT turns |
// |               each read into the matching write-back strobe and addresses. |
// | Ports       : clk, rst (async, active-high), start, mode (0=NTT, 1=INTT),  |
// |               [pause], busy, done, rd_en, rd_addr_u, rd_addr_v, tf_addr,   |
// |               pe_sel, wr_en, wr_addr_u, wr_addr_v                           |
// | Option      : PE0_ADDR_GEN_PAUSE_EN adds a `pause` input that stalls issue |
// |               and the inter-stage gap while in-flight writes complete.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pe0_addr_gen #(
  parameter int LOG_N  = 9,
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 7
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PE0_ADDR_GEN_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_u,
  output logic [LOG_N-1:0] rd_addr_v,
  output logic [LOG_N-1:0] tf_addr,
  output logic             pe_sel,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_u,
  output logic [LOG_N-1:0] wr_addr_v
);

  localparam int c_DLY = RD_LAT + PE_LAT;
  localparam int c_SW  = $clog2(LOG_N + 1);
  localparam int c_CW  = $clog2(c_DLY + 1);

  localparam logic [c_SW-1:0]  c_LAST_S  = c_SW'(LOG_N - 1);
  localparam logic [LOG_N-1:0] c_ONE     = LOG_N'(1);
  localparam logic [LOG_N-1:0] c_HALF    = LOG_N'(1 << (LOG_N - 1));
  localparam logic [LOG_N-1:0] c_LAST_J  = LOG_N'((1 << (LOG_N - 1)) - 1);
  localparam logic [c_CW-1:0]  c_CNT_END = c_CW'(c_DLY - 1);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_ISSUE = 3'd1;
  localparam logic [2:0] c_ST_GAP   = 3'd2;
  localparam logic [2:0] c_ST_DRAIN = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic             r_mode;
  logic [LOG_N-1:0] r_j;
  logic [c_SW-1:0]  r_s;
  logic [c_CW-1:0]  r_cnt;
  logic [LOG_N-1:0] r_hold_u;
  logic [LOG_N-1:0] r_hold_v;
  logic [LOG_N-1:0] r_hold_tf;

  logic [c_DLY-1:0] r_pipe_en;
  logic [LOG_N-1:0] r_pipe_u [c_DLY];
  logic [LOG_N-1:0] r_pipe_v [c_DLY];

  logic             w_pause;
  logic             w_fire;
  logic [c_SW-1:0]  w_sh_n;
  logic [LOG_N-1:0] w_len;
  logic [LOG_N-1:0] w_g;
  logic [LOG_N-1:0] w_k;
  logic [LOG_N-1:0] w_base;
  logic [LOG_N-1:0] w_u;
  logic [LOG_N-1:0] w_v;
  logic [LOG_N-1:0] w_tf;

`ifdef PE0_ADDR_GEN_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_fire = (r_state == c_ST_ISSUE) && !w_pause;

  // Butterfly addressing. NTT halves the span each stage, INTT doubles it;
  // g selects the butterfly group, k the offset inside the group.
  always_comb begin
    w_sh_n = c_LAST_S - r_s;
    if (r_mode) begin
      w_len  = c_ONE << r_s;
      w_g    = r_j >> r_s;
      w_base = (w_g << r_s) << 1;
      w_tf   = (c_HALF >> r_s) + w_g;
    end else begin
      w_len  = c_ONE << w_sh_n;
      w_g    = r_j >> w_sh_n;
      w_base = (w_g << w_sh_n) << 1;
      w_tf   = (c_ONE << r_s) + w_g;
    end
    w_k = r_j & (w_len - c_ONE);
    w_u = w_base + w_k;
    w_v = w_u + w_len;
  end

  // Read outputs follow the live computation while issuing and otherwise
  // hold the last issued butterfly (zero after reset).
  assign rd_en     = w_fire;
  assign rd_addr_u = w_fire ? w_u  : r_hold_u;
  assign rd_addr_v = w_fire ? w_v  : r_hold_v;
  assign tf_addr   = w_fire ? w_tf : r_hold_tf;
  assign pe_sel    = r_mode;
  assign busy      = (r_state != c_ST_IDLE);
  assign done      = (r_state == c_ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_u  <= '0;
      r_hold_v  <= '0;
      r_hold_tf <= '0;
    end else if (w_fire) begin
      r_hold_u  <= w_u;
      r_hold_v  <= w_v;
      r_hold_tf <= w_tf;
    end
  end

  // r_cnt is shared: it times the RAW-safety gap between stages and the
  // final drain until the last write-back leaves the delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_mode  <= 1'b0;
      r_j     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_state <= c_ST_ISSUE;
            r_mode  <= mode;
            r_j     <= '0;
            r_s     <= '0;
          end
        end
        c_ST_ISSUE: begin
          if (w_fire) begin
            if (r_j == c_LAST_J) begin
              r_j   <= '0;
              r_cnt <= '0;
              if (r_s == c_LAST_S) begin
                r_state <= c_ST_DRAIN;
              end else begin
                r_state <= c_ST_GAP;
                r_s     <= r_s + c_SW'(1);
              end
            end else begin
              r_j <= r_j + c_ONE;
            end
          end
        end
        c_ST_GAP: begin
          if (!w_pause) begin
            if (r_cnt == c_CNT_END) begin
              r_state <= c_ST_ISSUE;
            end else begin
              r_cnt <= r_cnt + c_CW'(1);
            end
          end
        end
        c_ST_DRAIN: begin
          if (r_cnt == c_CNT_END) begin
            r_state <= c_ST_DONE;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Write-back delay line; shifts every cycle regardless of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_en <= '0;
      for (int i = 0; i < c_DLY; i++) begin
        r_pipe_u[i] <= '0;
        r_pipe_v[i] <= '0;
      end
    end else begin
      r_pipe_en[0] <= rd_en;
      r_pipe_u[0]  <= rd_addr_u;
      r_pipe_v[0]  <= rd_addr_v;
      for (int i = 1; i < c_DLY; i++) begin
        r_pipe_en[i] <= r_pipe_en[i-1];
        r_pipe_u[i]  <= r_pipe_u[i-1];
        r_pipe_v[i]  <= r_pipe_v[i-1];
      end
    end
  end

  assign wr_en     = r_pipe_en[c_DLY-1];
  assign wr_addr_u = r_pipe_u[c_DLY-1];
  assign wr_addr_v = r_pipe_v[c_DLY-1];

endmodule
`default_nettype wire

// File: tb/tb_pe0_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pe0_addr_gen                                              |
// | Description : Randomized scoreboard bench for pe0_addr_gen (LOG_N=3).      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pe0_addr_gen;

  localparam int LOG_N  = 3;
  localparam int RD_LAT = 1;
  localparam int PE_LAT = 7;
  localparam int N      = 1 << LOG_N;
  localparam int HB     = N / 2;
  localparam int D      = RD_LAT + PE_LAT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
`ifdef PE0_ADDR_GEN_PAUSE_EN
  logic             pause = 1'b0;
`endif
  logic             busy, done, rd_en, pe_sel, wr_en;
  logic [LOG_N-1:0] rd_addr_u, rd_addr_v, tf_addr, wr_addr_u, wr_addr_v;

  pe0_addr_gen #(.LOG_N(LOG_N), .RD_LAT(RD_LAT), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst),
`ifdef PE0_ADDR_GEN_PAUSE_EN
    .pause(pause),
`endif
    .start(start), .mode(mode), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_u(rd_addr_u), .rd_addr_v(rd_addr_v), .tf_addr(tf_addr),
    .pe_sel(pe_sel), .wr_en(wr_en), .wr_addr_u(wr_addr_u), .wr_addr_v(wr_addr_v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int u; int v; int tf; int c;} rd_t;
  typedef struct {int u; int v; int c;} wr_t;
  rd_t rdq[$];
  wr_t wrq[$];

  int vectors = 0;
  int errors  = 0;
  bit mon_en  = 1'b0;
  bit active  = 1'b0;
  bit exp_sel = 1'b0;
  int busy_lo = 0;
  int done_c  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: enumerate butterflies group by group, as the transform
  // definition reads, and stamp each with the cycle it must be issued in.
  task automatic push_transform(input bit m, input int c0);
    int len, tf, last_rd;
    for (int s = 0; s < LOG_N; s++) begin
      len = m ? (1 << s) : (N >> (s + 1));
      for (int g = 0; g < HB / len; g++) begin
        for (int k = 0; k < len; k++) begin
          rd_t e;
          tf = m ? ((N >> (s + 1)) + g) : ((1 << s) + g);
          e.u = 2 * g * len + k;
          e.v = e.u + len;
          e.tf = tf;
          e.c = c0 + 1 + s * (HB + D) + g * len + k;
          rdq.push_back(e);
        end
      end
    end
    last_rd = c0 + (LOG_N - 1) * (HB + D) + HB;
    done_c  = last_rd + D + 1;
    busy_lo = c0 + 1;
    exp_sel = m;
    active  = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a read or write.
  always @(negedge clk) begin
    rd_t er;
    wr_t ew;
    if (mon_en) begin
      if (active && cyc > done_c) active = 1'b0;
      chk("busy", busy, active && cyc >= busy_lo && cyc <= done_c);
      chk("done", done, active && cyc == done_c);
      if (rd_en) begin
        if (rdq.size() == 0) begin
          chk("unexpected_rd_en", 1, 0);
        end else begin
          er = rdq.pop_front();
          chk("rd_cycle", cyc, er.c);
          chk("rd_addr_u", rd_addr_u, er.u);
          chk("rd_addr_v", rd_addr_v, er.v);
          chk("tf_addr", tf_addr, er.tf);
          chk("pe_sel", pe_sel, exp_sel);
          ew.u = er.u; ew.v = er.v; ew.c = er.c + D;
          wrq.push_back(ew);
        end
      end
      if (wr_en) begin
        if (wrq.size() == 0) begin
          chk("unexpected_wr_en", 1, 0);
        end else begin
          ew = wrq.pop_front();
          chk("wr_cycle", cyc, ew.c);
          chk("wr_addr_u", wr_addr_u, ew.u);
          chk("wr_addr_v", wr_addr_v, ew.v);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr_u"}, rd_addr_u, 0);
    chk({tag, "_rd_addr_v"}, rd_addr_v, 0);
    chk({tag, "_tf_addr"}, tf_addr, 0);
    chk({tag, "_pe_sel"}, pe_sel, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr_u"}, wr_addr_u, 0);
    chk({tag, "_wr_addr_v"}, wr_addr_v, 0);
  endtask

  // Called at posedge+2; start is high for the current cycle only.
  task automatic do_start(input bit m);
    start = 1'b1;
    mode  = m;
    push_transform(m, cyc);
    @(posedge clk); #2;
    start = 1'b0;
    mode  = 1'($urandom);
  endtask

  task automatic run_to_done(input bit m);
    int ign_c;
    do_start(m);
    ign_c = $urandom_range(done_c, cyc);
    do begin
      @(posedge clk); #2;
      start = (cyc == ign_c) && (cyc <= done_c);
      if (start) mode = 1'($urandom);
    end while (cyc <= done_c);
    start = 1'b0;
  endtask

  initial begin
    int target;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #2;
    mon_en = 1'b1;

    run_to_done(1'b0);
    run_to_done(1'b1);
    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #2;
      end
      run_to_done(1'($urandom));
    end

    // Reset in the middle of stage 1, then confirm silence and a clean rerun.
    do_start(1'($urandom));
    target = busy_lo + HB + D + 1;
    while (cyc < target) begin
      @(posedge clk); #2;
    end
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #2;
    rst = 1'b0;
    rdq.delete();
    wrq.delete();
    active = 1'b0;
    mon_en = 1'b1;
    repeat (20) begin
      @(posedge clk); #2;
    end
    run_to_done(1'b1);
    run_to_done(1'b0);
    repeat (3) begin
      @(posedge clk); #2;
    end

    chk("rd_queue_empty", rdq.size(), 0);
    chk("wr_queue_empty", wrq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
